// File: rtl/arb_pkg.sv
// Shared types and defaults for the request/grant arbiter.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } arb_state_t;

   localparam int ARB_N_DEFAULT = 6;

endpackage

// File: rtl/priority_pick.sv
// Combinational priority picker: the highest-index set bit of req wins.
module priority_pick #(
   parameter int  N   = 6,
   localparam int IDW = $clog2(N)
) (
   input  logic [N-1:0]   req,
   output logic [N-1:0]   onehot,
   output logic [IDW-1:0] index,
   output logic           none
);

   always_comb begin
      onehot = '0;
      index  = '0;
      none   = 1'b1;
      // Ascending scan: the last set bit seen is the highest index.
      for (int i = 0; i < N; i++) begin
         if (req[i]) begin
            onehot    = '0;
            onehot[i] = 1'b1;
            index     = IDW'(i);
            none      = 1'b0;
         end
      end
   end

endmodule

// File: rtl/req_grant_arbiter.sv
// Registered N-way arbiter with hold timeout and one dead cycle between owners.
// Define ROUND_ROBIN_EN for rotating priority; otherwise req[N-1] is highest.
module req_grant_arbiter
   import arb_pkg::*;
#(
   parameter int  N        = ARB_N_DEFAULT,
   parameter int  MAX_HOLD = 8,
   localparam int IDW      = $clog2(N)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   gnt,
   output logic           gnt_valid,
   output logic [IDW-1:0] gnt_id,
   output logic           idle,
   output logic           timeout
);

   localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

   arb_state_t     state;
   logic [HW-1:0]  hold_cnt;
   logic [N-1:0]   excl;
   logic [N-1:0]   cand;
   logic [N-1:0]   rot;
   logic [N-1:0]   pick_onehot;
   logic [IDW-1:0] pick_index;
   logic           pick_none;
   logic [N-1:0]   win_oh;
   logic [IDW-1:0] win_id;
   logic           release_hit;
   logic           limit_hit;

   // Only a timed-out owner is excluded, and only in the RELEASE cycle.
   always_comb begin
      cand = (state == RELEASE) ? (req & ~excl) : req;
   end

`ifdef ROUND_ROBIN_EN
   logic [IDW-1:0] rr_ptr;
   logic           rr_any;
   logic [IDW-1:0] base;

   // Before the first grant, base 0 makes the pick identical to fixed priority.
   always_comb begin
      base   = rr_any ? rr_ptr : '0;
      rot    = '0;
      win_oh = '0;
      for (int j = 0; j < N; j++) begin
         rot[j]                                  = cand[IDW'((j + int'(base)) % N)];
         win_oh[IDW'((j + int'(base)) % N)]      = pick_onehot[j];
      end
      win_id = IDW'((int'(pick_index) + int'(base)) % N);
   end
`else
   always_comb begin
      rot    = cand;
      win_oh = pick_onehot;
      win_id = pick_index;
   end
`endif

   priority_pick #(.N(N)) u_pick (
      .req    (rot),
      .onehot (pick_onehot),
      .index  (pick_index),
      .none   (pick_none)
   );

   always_comb begin
      release_hit = ((req & gnt) == '0);
      limit_hit   = (MAX_HOLD != 0) && (hold_cnt == HW'(MAX_HOLD - 1));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         gnt      <= '0;
         gnt_id   <= '0;
         idle     <= 1'b1;
         timeout  <= 1'b0;
         hold_cnt <= '0;
         excl     <= '0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE, RELEASE: begin
               excl <= '0;
               if (!pick_none) begin
                  state    <= GRANT;
                  gnt      <= win_oh;
                  gnt_id   <= win_id;
                  hold_cnt <= '0;
                  idle     <= 1'b0;
               end else begin
                  state  <= IDLE;
                  gnt    <= '0;
                  gnt_id <= '0;
                  idle   <= 1'b1;
               end
            end
            GRANT: begin
               if (release_hit || limit_hit) begin
                  state   <= RELEASE;
                  gnt     <= '0;
                  gnt_id  <= '0;
                  timeout <= !release_hit;
                  excl    <= release_hit ? '0 : gnt;
               end else if (hold_cnt != '1) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               gnt    <= '0;
               gnt_id <= '0;
               idle   <= 1'b1;
            end
         endcase
      end
   end

`ifdef ROUND_ROBIN_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr <= IDW'(N - 1);
         rr_any <= 1'b0;
      end else if ((state == IDLE || state == RELEASE) && !pick_none) begin
         rr_ptr <= win_id;
         rr_any <= 1'b1;
      end
   end
`endif

   assign gnt_valid = |gnt;

endmodule

// File: tb/tb_req_grant_arbiter.sv
// Self-checking bench for req_grant_arbiter against a cycle-level owner model.
module tb_req_grant_arbiter;

   localparam int N        = 6;
   localparam int MAX_HOLD = 8;
   localparam int IDW      = $clog2(N);

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req;
   logic [N-1:0]   gnt;
   logic           gnt_valid;
   logic [IDW-1:0] gnt_id;
   logic           idle;
   logic           timeout;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: who owns the resource, for how long, and the gap state.
   int owner    = -1;
   int held     = 0;
   bit in_gap   = 1'b0;
   int excluded = -1;
   bit exp_to   = 1'b0;
   int rr_last  = N - 1;
   bit rr_fresh = 1'b1;

   req_grant_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id),
      .idle      (idle),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   function automatic int pick(input logic [N-1:0] v, input int skip);
      int start;
      int idx;
      start = N - 1;
`ifdef ROUND_ROBIN_EN
      if (!rr_fresh) start = (rr_last + N - 1) % N;
`endif
      for (int k = 0; k < N; k++) begin
         idx = (start - k + N) % N;
         if (v[idx] && idx != skip) return idx;
      end
      return -1;
   endfunction

   task automatic model_edge(input logic [N-1:0] r, input logic rs);
      int w;
      exp_to = 1'b0;
      if (rs) begin
         owner = -1; held = 0; in_gap = 1'b0; excluded = -1;
         rr_last = N - 1; rr_fresh = 1'b1;
      end else if (owner >= 0) begin
         held++;
         if (!r[owner]) begin
            owner = -1; in_gap = 1'b1; excluded = -1;
         end else if (MAX_HOLD != 0 && held == MAX_HOLD) begin
            excluded = owner; owner = -1; in_gap = 1'b1; exp_to = 1'b1;
         end
      end else begin
         w = pick(r, in_gap ? excluded : -1);
         in_gap = 1'b0;
         excluded = -1;
         if (w >= 0) begin
            owner = w; held = 0; rr_last = w; rr_fresh = 1'b0;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      logic [N-1:0] eg;
      eg = '0;
      if (owner >= 0) eg[owner] = 1'b1;
      chk("gnt", 32'(gnt), 32'(eg));
      chk("gnt_id", 32'(gnt_id), (owner >= 0) ? 32'(owner) : 32'd0);
      chk("gnt_valid", 32'(gnt_valid), 32'(owner >= 0));
      chk("idle", 32'(idle), 32'(owner < 0 && !in_gap));
      chk("timeout", 32'(timeout), 32'(exp_to));
   endtask

   task automatic step(input logic [N-1:0] r, input logic rs);
      req   = r;
      reset = rs;
      @(posedge clk);
      model_edge(r, rs);
      #1;
      check_outputs();
   endtask

   initial begin
      logic [N-1:0] r;
      reset = 1'b1;
      req   = 6'b101010;

      // Reset with pending requests, then first grant goes to id 5.
      step(6'b101010, 1'b1);
      step(6'b101010, 1'b1);
      chk("reset_idle_direct", 32'(idle), 32'd1);
      step(6'b101010, 1'b0);
      chk("first_gnt_direct", 32'(gnt), 32'(6'b100000));
      step(6'b000000, 1'b0);
      step(6'b000000, 1'b0);

      // Owner 2 holds, drops, one dead cycle, then 0.
      for (int i = 0; i < 4; i++) step(6'b000101, 1'b0);
      step(6'b000001, 1'b0);
      step(6'b000001, 1'b0);
      step(6'b000001, 1'b0);
      step(6'b000000, 1'b0);
      step(6'b000000, 1'b0);

      // Timeout with a competitor, then sole-requester timeout with gap.
      for (int i = 0; i < 14; i++) step(6'b100001, 1'b0);
      step(6'b000000, 1'b0);
      step(6'b000000, 1'b0);
      for (int i = 0; i < 13; i++) step(6'b010000, 1'b0);
      step(6'b000000, 1'b0);
      step(6'b000000, 1'b0);

      // All requesting, owner drops its bit each grant.
      for (int i = 0; i < 24; i++) begin
         r = 6'b111111;
         if (owner >= 0) r[owner] = 1'b0;
         step(r, 1'b0);
      end
      step(6'b000000, 1'b0);
      step(6'b000000, 1'b0);

      // Release coinciding with the hold limit: no timeout pulse.
      for (int i = 0; i < 8; i++) step(6'b000010, 1'b0);
      step(6'b000000, 1'b0);
      step(6'b000000, 1'b0);

      // Reset in the middle of a grant to id 3.
      step(6'b001000, 1'b0);
      step(6'b001000, 1'b0);
      step(6'b001000, 1'b1);
      chk("reset_mid_gnt_direct", 32'(gnt), 32'd0);
      step(6'b111000, 1'b0);
      step(6'b111000, 1'b0);

      // Randomized traffic, mostly sticky requests so timeouts occur.
      r = '0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, (1 << N) - 1));
         step(r, ($urandom_range(0, 79) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
